// File: rtl/scene_seq_pkg.sv
// rtl/scene_seq_pkg.sv - shared state encoding and brightness limits for scene_sequencer.
package scene_seq_pkg;

  typedef enum logic [1:0] {
    FADE_IN  = 2'd0,
    HOLD     = 2'd1,
    FADE_OUT = 2'd2,
    SWITCH   = 2'd3
  } state_t;

  localparam logic [3:0] BRIGHT_MAX = 4'hF;
  localparam logic [3:0] BRIGHT_MIN = 4'h0;

  // Counter width for a terminal count of n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer, stable-time debouncer and rising-edge press pulse.
module btn_debounce
  import scene_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized input disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = level_q & ~level_prev_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= press_d;
      cnt_q        <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/scene_sequencer.sv
// rtl/scene_sequencer.sv - frame-synchronous effect scheduler with fade-in, hold, fade-out and button skip.
// Define SCENE_SEQ_AUTOPLAY_EN to let HOLD expire after HOLD_FRAMES; otherwise HOLD lasts until a skip.
module scene_sequencer
  import scene_seq_pkg::*;
#(
  parameter int NUM_SCENES       = 4,
  parameter int HOLD_FRAMES      = 600,
  parameter int FADE_STEP_FRAMES = 4,
  parameter int DEBOUNCE_CYCLES  = 250000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          btn,
  output logic [$clog2(NUM_SCENES)-1:0] scene_sel,
  output logic [3:0]                    brightness,
  output logic                          scene_change
);

  localparam int SEL_W  = $clog2(NUM_SCENES);
  localparam int STEP_W = cnt_width(FADE_STEP_FRAMES);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_SCENES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FADE_STEP_FRAMES - 1);

  state_t            state_q, state_d;
  logic [3:0]        brightness_q, brightness_d;
  logic [SEL_W-1:0]  scene_sel_q, scene_sel_d;
  logic              scene_change_q, scene_change_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              skip_q, skip_d;
  logic              skip_now;
  logic              press;

`ifdef SCENE_SEQ_AUTOPLAY_EN
  localparam int HOLD_W = cnt_width(HOLD_FRAMES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
`endif

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .reset(reset),
    .btn  (btn),
    .press(press)
  );

  // A press landing on the frame_start cycle is folded in so it acts on that frame.
  assign skip_now = skip_q | press;

  always_comb begin
    state_d        = state_q;
    brightness_d   = brightness_q;
    scene_sel_d    = scene_sel_q;
    scene_change_d = 1'b0;
    step_d         = step_q;
    skip_d         = ((state_q == FADE_IN) || (state_q == HOLD)) ? skip_now : 1'b0;
`ifdef SCENE_SEQ_AUTOPLAY_EN
    hold_d         = hold_q;
`endif
    if (frame_start) begin
      case (state_q)
        FADE_IN, HOLD: begin
          if (skip_now) begin
            state_d = FADE_OUT;
            step_d  = '0;
            skip_d  = 1'b0;
`ifdef SCENE_SEQ_AUTOPLAY_EN
            hold_d  = '0;
`endif
          end else if (state_q == FADE_IN) begin
            if (step_q == STEP_LAST) begin
              step_d = '0;
              brightness_d = (brightness_q == BRIGHT_MAX) ? BRIGHT_MAX : brightness_q + 4'd1;
              if (brightness_q >= BRIGHT_MAX - 4'd1) begin
                state_d = HOLD;
`ifdef SCENE_SEQ_AUTOPLAY_EN
                hold_d  = '0;
`endif
              end
            end else begin
              step_d = step_q + 1'b1;
            end
          end else begin
`ifdef SCENE_SEQ_AUTOPLAY_EN
            if (hold_q == HOLD_LAST) begin
              state_d = FADE_OUT;
              step_d  = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
`endif
          end
        end
        FADE_OUT: begin
          if (step_q == STEP_LAST) begin
            step_d = '0;
            brightness_d = (brightness_q == BRIGHT_MIN) ? BRIGHT_MIN : brightness_q - 4'd1;
            if (brightness_q <= 4'd1) begin
              state_d = SWITCH;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        default: begin
          scene_sel_d    = (scene_sel_q == SEL_LAST) ? '0 : scene_sel_q + 1'b1;
          scene_change_d = 1'b1;
          state_d        = FADE_IN;
          step_d         = '0;
          brightness_d   = BRIGHT_MIN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= FADE_IN;
      brightness_q   <= BRIGHT_MIN;
      scene_sel_q    <= '0;
      scene_change_q <= 1'b0;
      step_q         <= '0;
      skip_q         <= 1'b0;
`ifdef SCENE_SEQ_AUTOPLAY_EN
      hold_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      brightness_q   <= brightness_d;
      scene_sel_q    <= scene_sel_d;
      scene_change_q <= scene_change_d;
      step_q         <= step_d;
      skip_q         <= skip_d;
`ifdef SCENE_SEQ_AUTOPLAY_EN
      hold_q         <= hold_d;
`endif
    end
  end

  assign scene_sel    = scene_sel_q;
  assign brightness   = brightness_q;
  assign scene_change = scene_change_q;

endmodule

// File: tb/tb_scene_sequencer.sv
// tb/tb_scene_sequencer.sv - scoreboard bench for scene_sequencer against a frame-level reference model.
module tb_scene_sequencer;

  localparam int NS    = 3;
  localparam int HF    = 5;
  localparam int FSF   = 2;
  localparam int DB    = 8;
  localparam int FRAME = 20;

`ifdef SCENE_SEQ_AUTOPLAY_EN
  localparam bit AUTOPLAY = 1'b1;
`else
  localparam bit AUTOPLAY = 1'b0;
`endif
  localparam int EXP_B65  = AUTOPLAY ? 0 : 15;
  localparam int EXP_S66  = AUTOPLAY ? 1 : 0;

  localparam int P_IN = 0, P_HOLD = 1, P_OUT = 2, P_SW = 3;

  logic       clk, reset, frame_start, btn;
  logic [1:0] scene_sel;
  logic [3:0] brightness;
  logic       scene_change;

  scene_sequencer #(
    .NUM_SCENES      (NS),
    .HOLD_FRAMES     (HF),
    .FADE_STEP_FRAMES(FSF),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .btn         (btn),
    .scene_sel   (scene_sel),
    .brightness  (brightness),
    .scene_change(scene_change)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int b;
    int s;
    int c;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  logic fs_seen = 1'b0;

  int m_phase, m_n, m_base, m_b, m_scene, m_skip, m_change;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = P_IN; m_n = 0; m_base = 0; m_b = 0; m_scene = 0; m_skip = 0; m_change = 0;
  endfunction

  // Frame-level behaviour: brightness is derived from frames elapsed in the current phase.
  function automatic void model_frame();
    m_change = 0;
    case (m_phase)
      P_IN, P_HOLD: begin
        if (m_skip != 0) begin
          m_phase = P_OUT; m_base = m_b; m_n = 0; m_skip = 0;
        end else if (m_phase == P_IN) begin
          m_n++;
          m_b = (m_n / FSF > 15) ? 15 : m_n / FSF;
          if (m_b == 15) begin m_phase = P_HOLD; m_n = 0; end
        end else begin
          m_n++;
          if (AUTOPLAY && m_n == HF) begin m_phase = P_OUT; m_base = 15; m_n = 0; end
        end
      end
      P_OUT: begin
        m_skip = 0;
        m_n++;
        m_b = (m_base - m_n / FSF < 0) ? 0 : m_base - m_n / FSF;
        if (m_b == 0 && (m_n % FSF) == 0) m_phase = P_SW;
      end
      default: begin
        m_skip = 0;
        m_scene = (m_scene + 1) % NS;
        m_change = 1;
        m_phase = P_IN; m_n = 0; m_b = 0;
      end
    endcase
  endfunction

  // mode 0: idle, 1: clean press of arg clocks, 2: bounce toggling every 3 clocks (arg = phase offset)
  task automatic run_frame(input int mode, input int arg);
    for (int k = 0; k < FRAME; k++) begin
      frame_start = (k == 0);
      case (mode)
        1:       btn = (k >= 1) && (k < 1 + arg);
        2:       btn = (((k + arg) / 3) % 2) == 1;
        default: btn = 1'b0;
      endcase
      if (k == 0) begin
        model_frame();
        q.push_back('{b: m_b, s: m_scene, c: m_change});
        if (mode == 1 && (m_phase == P_IN || m_phase == P_HOLD)) m_skip = 1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk) fs_seen <= frame_start && !reset;

  always @(negedge clk) begin
    if (!reset) begin
      if (fs_seen) begin
        if (q.size() == 0) begin
          check("scoreboard_underflow", 1, 0);
        end else begin
          e = q.pop_front();
          check("brightness", int'(brightness), e.b);
          check("scene_sel", int'(scene_sel), e.s);
          check("scene_change", int'(scene_change), e.c);
        end
      end else begin
        check("scene_change_idle", int'(scene_change), 0);
      end
    end
  end

  initial begin
    int prev_press;
    int mode;
    int wrapped;
    reset = 1'b1; frame_start = 1'b0; btn = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_brightness", int'(brightness), 0);
    check("reset_scene_sel", int'(scene_sel), 0);
    check("reset_scene_change", int'(scene_change), 0);
    repeat (2) begin @(posedge clk); #1; end

    for (int i = 1; i <= 66; i++) begin
      run_frame(0, 0);
      if (i == 2)  check("bright_after_f2", int'(brightness), 1);
      if (i == 30) check("bright_after_f30", int'(brightness), 15);
      if (i == 65) check("bright_after_f65", int'(brightness), EXP_B65);
      if (i == 66) check("scene_after_f66", int'(scene_sel), EXP_S66);
    end

    for (int i = 0; i < 60 && m_phase != P_HOLD; i++) run_frame(0, 0);
    check("reached_hold", int'(brightness), 15);
    run_frame(1, 12);
    run_frame(0, 0);
    check("skip_enters_fade_from_15", int'(brightness), 15);
    run_frame(0, 0);
    run_frame(1, 12);
    for (int i = 0; i < 60 && !(m_phase == P_OUT && m_b == 7); i++) run_frame(0, 0);
    check("mid_fade_bright_7", int'(brightness), 7);

    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    check("midreset_brightness", int'(brightness), 0);
    check("midreset_scene_sel", int'(scene_sel), 0);
    check("midreset_scene_change", int'(scene_change), 0);
    repeat (2) begin @(posedge clk); #1; end

    run_frame(0, 0);
    run_frame(2, 0);
    run_frame(2, 20);
    for (int i = 0; i < 3; i++) run_frame(0, 0);

    for (int i = 0; i < 60 && m_phase != P_HOLD; i++) run_frame(0, 0);
    for (int i = 0; i < 200; i++) run_frame(0, 0);

    wrapped = 0;
    prev_press = 0;
    for (int i = 0; i < 800 && wrapped == 0; i++) begin
      mode = (prev_press == 0 && m_phase == P_HOLD) ? 1 : 0;
      if (m_change != 0 && m_scene == 0) wrapped = 1;
      run_frame(mode, 12);
      prev_press = (mode == 1);
    end

    prev_press = 0;
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(9, 0));
      if (prev_press != 0)  mode = 0;
      else if (r < 2)       mode = 1;
      else if (r < 3)       mode = 2;
      else                  mode = 0;
      run_frame(mode, (mode == 1) ? int'($urandom_range(14, 10)) : 0);
      prev_press = (mode == 1);
    end

    repeat (3) begin @(posedge clk); #1; end
    check("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
